btc_iter_ctrl: RTL and testbench
================================

# btc_iter_ctrl

Iteration controller for the block turbo code decoder. It sequences row and column half-iterations over a DIM x DIM product-code block held in the decoder's working memory, and issues one codeword request per row or column to the shared SISO decoder core. It also collects per-codeword syndrome results and stops on convergence or when the iteration limit is reached. It sits between the frame-level control (start/done) and the decoder datapath.

## Interface
- DIM, 32: rows = columns of the product-code block; power of two, ≥ 2.
- ITER_W, 4: width of the iteration limit and iteration count.
- IDX_W, $clog2(DIM): width of the codeword index.

- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin decoding a block; sampled only in IDLE.
- abort  in  1  synchronous cancel; return to IDLE next cycle, no done pulse.
- max_iter  in  ITER_W  full-iteration limit, latched at start; 0 is treated as 1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at block completion.
- converged  out  1  valid with done and held until the next start; 1 means an all-ok half-iteration occurred.
- iter_count  out  ITER_W  completed full iterations; held after done, cleared at start.
- dec_req  out  1  codeword request valid.
- dec_ack  in  1  decoder accepts the request this cycle (valid/ready).
- dec_dir  out  1  0 = row pass, 1 = column pass.
- dec_idx  out  IDX_W  row or column index of the request.
- res_valid  in  1  one result per accepted request, in request order, at the earliest the cycle after its ack.
- res_ok  in  1  syndrome of that codeword is zero.
- res_err  out  1  sticky; set on a res_valid with no outstanding request; cleared at start.

## Operation
- States: IDLE, ROW, COL, DONE.
- IDLE: start=1 latches max(max_iter,1), clears iter_count, converged and res_err, then moves to ROW.
- ROW and COL are phases. Each phase issues indexes 0..DIM-1 in order, with dec_dir fixed for the phase.
  - dec_req and dec_idx are held stable until dec_ack.
  - After the ack of index DIM-1, dec_req drops and the phase drains the remaining results.
- Each phase tracks issued count, result count, and all_ok, which is the AND of res_ok over the phase.
- A phase completes when both the issued count and the result count equal DIM. Counters are IDX_W+1 bits wide.
- On phase completion:
  - If all_ok = 1: converged=1, go to DONE. An early stop from ROW does not increment iter_count.
  - ROW with all_ok = 0: go to COL.
  - COL with all_ok = 0: iter_count+1. If the new value equals the limit, go to DONE with converged=0; otherwise go to ROW.
- DONE: done=1 for one cycle, then IDLE.
- abort in ROW, COL or DONE: go to IDLE and drop dec_req.
  - Results arriving later, in IDLE, are ignored and do not set res_err.
- res_valid in ROW/COL with result count equal to issued count sets res_err and is otherwise ignored.
- start while busy is ignored.
- Reset: state IDLE; busy, done, converged, dec_req, dec_dir, res_err are 0; dec_idx and iter_count are 0.

## Timing
- Start accepted in cycle T: dec_req=1 with dec_idx=0 and dec_dir=0 in cycle T+1.
- An ack in cycle t advances dec_idx in cycle t+1. With dec_ack held high, one request is issued per cycle.
- The result that completes a phase arrives in cycle t. The next phase's first dec_req appears in t+1, or DONE (done=1) in t+1.
- Minimum phase length is DIM+1 cycles: ack always high, each result exactly one cycle after its ack.
- A result and the next ack in the same cycle are both counted.

## Structure
- Package btc_pkg holds:
  - the state enum (IDLE, ROW, COL, DONE);
  - the DIR_ROW and DIR_COL constants;
  - the shared DIM default, so the encoder and decoder agree on it.
- Sub-module btc_phase_tracker holds the issue counter, result counter, all_ok and res_err detection, and outputs phase_done.
  - It is instantiated once and cleared on each phase entry.

## Test plan
- DIM=4, max_iter=2, ack always high, each result 1 cycle after its ack, res_ok=0 throughout → ROW, COL, ROW, COL; 16 requests; done at the end with converged=0 and iter_count=2.
- DIM=4, max_iter=3, all res_ok=1 in the first COL phase → done after 8 requests, converged=1, iter_count=1.
- dec_ack low for 3 cycles on idx 2 → dec_idx holds 2 and dec_req stays high; no skipped or duplicated index.
- Results delayed 5 cycles after ack → the phase does not advance until the 4th result; the next phase starts the cycle after it.
- abort mid-COL with 2 results still outstanding → IDLE next cycle, no done pulse, late results ignored, res_err=0. A following start runs normally.
- max_iter=0 → behaves as 1. Also: a spurious res_valid while in ROW with no outstanding request sets res_err=1; rst_n asserted mid-ROW clears all outputs immediately.

Source files
------------

// File: rtl/btc_pkg.sv
// Purpose : shared constants for the block turbo code encoder/decoder control.
// Latency : n/a (package only).
// Backpressure: n/a.
package btc_pkg;

  // Block dimension shared by encoder and decoder; rows = columns = BTC_DIM.
  localparam int BTC_DIM = 32;

  // Iteration controller states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ROW  = 2'd1;
  localparam logic [1:0] ST_COL  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Codeword direction presented to the SISO core.
  localparam logic DIR_ROW = 1'b0;
  localparam logic DIR_COL = 1'b1;

endpackage

// File: rtl/btc_phase_tracker.sv
// Purpose : per-phase bookkeeping: issued/result counts, AND of syndrome-ok, spurious-result detect.
// Latency : phase_done is combinational with the result that completes the phase.
// Backpressure: none; counts whatever issue/res_valid it is shown while active.
// Ports   : clr zeroes the phase; active gates all counting; issue = accepted request;
//           res_valid/res_ok = decoder result; issued_cnt, all_ok, phase_done, res_spur out.
module btc_phase_tracker
  import btc_pkg::*;
#(
  parameter int DIM   = BTC_DIM,
  parameter int IDX_W = $clog2(DIM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             active,
  input  logic             issue,
  input  logic             res_valid,
  input  logic             res_ok,
  output logic [IDX_W:0]   issued_cnt,
  output logic             all_ok,
  output logic             phase_done,
  output logic             res_spur
);

  localparam int CW = IDX_W + 1;
  localparam logic [IDX_W:0] FULL = CW'(DIM);

  logic [IDX_W:0] issued_q;
  logic [IDX_W:0] res_q;
  logic [IDX_W:0] res_cnt_nxt;
  logic           all_ok_q;
  logic           res_take;

  // A result with nothing outstanding is flagged and not counted.
  assign res_spur    = active & res_valid & (res_q == issued_q);
  assign res_take    = active & res_valid & ~res_spur;
  assign res_cnt_nxt = res_q + CW'(res_take);

  // Fold the in-flight result in so the completing result is judged in its own cycle.
  assign all_ok     = all_ok_q & (~res_take | res_ok);
  assign phase_done = active & (issued_q == FULL) & (res_cnt_nxt == FULL);
  assign issued_cnt = issued_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      res_q    <= '0;
      all_ok_q <= 1'b1;
    end else if (clr) begin
      issued_q <= '0;
      res_q    <= '0;
      all_ok_q <= 1'b1;
    end else if (active) begin
      if (issue) begin
        issued_q <= issued_q + CW'(1);
      end
      res_q    <= res_cnt_nxt;
      all_ok_q <= all_ok;
    end
  end

endmodule

// File: rtl/btc_iter_ctrl.sv
// Purpose : sequences row/column half-iterations of a DIM x DIM product-code block, stops on convergence or limit.
// Latency : first request 1 cycle after start; next phase or done 1 cycle after the phase's last result.
// Backpressure: dec_req/dec_idx held until dec_ack; results may lag acks arbitrarily, in order.
// Ports   : start/abort/max_iter frame control; busy/done/converged/iter_count status;
//           dec_req/dec_ack/dec_dir/dec_idx request handshake; res_valid/res_ok results; res_err sticky.
module btc_iter_ctrl
  import btc_pkg::*;
#(
  parameter int DIM    = BTC_DIM,
  parameter int ITER_W = 4,
  parameter int IDX_W  = $clog2(DIM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] max_iter,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITER_W-1:0] iter_count,
  output logic              dec_req,
  input  logic              dec_ack,
  output logic              dec_dir,
  output logic [IDX_W-1:0]  dec_idx,
  input  logic              res_valid,
  input  logic              res_ok,
  output logic              res_err
);

  localparam int CW = IDX_W + 1;
  localparam logic [IDX_W:0] FULL = CW'(DIM);

  logic [1:0]        state_q;
  logic [ITER_W-1:0] limit_q;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] iter_inc;
  logic              conv_q;
  logic              err_q;

  logic              active;
  logic              start_acc;
  logic              clr;
  logic [IDX_W:0]    issued_cnt;
  logic              all_ok;
  logic              phase_done;
  logic              res_spur;

  assign active    = (state_q == ST_ROW) | (state_q == ST_COL);
  assign start_acc = (state_q == ST_IDLE) & start;
  // Leaving a phase for any reason wipes the tracker, so dec_idx reads 0 outside a phase.
  assign clr       = start_acc | (active & (phase_done | abort));
  assign iter_inc  = iter_q + ITER_W'(1);

  btc_phase_tracker #(
    .DIM   (DIM),
    .IDX_W (IDX_W)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .active     (active),
    .issue      (dec_req & dec_ack),
    .res_valid  (res_valid),
    .res_ok     (res_ok),
    .issued_cnt (issued_cnt),
    .all_ok     (all_ok),
    .phase_done (phase_done),
    .res_spur   (res_spur)
  );

  assign dec_req    = active & (issued_cnt != FULL);
  assign dec_idx    = issued_cnt[IDX_W-1:0];
  assign dec_dir    = (state_q == ST_COL) ? DIR_COL : DIR_ROW;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign converged  = conv_q;
  assign iter_count = iter_q;
  assign res_err    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      limit_q <= ITER_W'(1);
      iter_q  <= '0;
      conv_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (res_spur) begin
        err_q <= 1'b1;
      end
      if (abort && state_q != ST_IDLE) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q <= ST_ROW;
              limit_q <= (max_iter == '0) ? ITER_W'(1) : max_iter;
              iter_q  <= '0;
              conv_q  <= 1'b0;
              err_q   <= 1'b0;
            end
          end
          ST_ROW: begin
            if (phase_done) begin
              if (all_ok) begin
                conv_q  <= 1'b1;
                state_q <= ST_DONE;
              end else begin
                state_q <= ST_COL;
              end
            end
          end
          ST_COL: begin
            if (phase_done) begin
              // A column pass closes a full iteration whether or not it converged.
              iter_q <= iter_inc;
              if (all_ok) begin
                conv_q  <= 1'b1;
                state_q <= ST_DONE;
              end else if (iter_inc == limit_q) begin
                state_q <= ST_DONE;
              end else begin
                state_q <= ST_ROW;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btc_iter_ctrl.sv
module tb_btc_iter_ctrl;

  localparam int DIM    = 4;
  localparam int ITER_W = 4;
  localparam int IDX_W  = 2;
  localparam int MAXPH  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [ITER_W-1:0] max_iter;
  logic              busy;
  logic              done;
  logic              converged;
  logic [ITER_W-1:0] iter_count;
  logic              dec_req;
  logic              dec_ack;
  logic              dec_dir;
  logic [IDX_W-1:0]  dec_idx;
  logic              res_valid;
  logic              res_ok;
  logic              res_err;

  int checks = 0;
  int errors = 0;

  // Per-phase stimulus: phase_ok[p] makes every codeword of phase p pass,
  // otherwise codeword bad_idx[p] fails and the rest are random.
  bit phase_ok[MAXPH];
  int bad_idx[MAXPH];

  always #5 clk = ~clk;

  btc_iter_ctrl #(
    .DIM    (DIM),
    .ITER_W (ITER_W),
    .IDX_W  (IDX_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .max_iter   (max_iter),
    .busy       (busy),
    .done       (done),
    .converged  (converged),
    .iter_count (iter_count),
    .dec_req    (dec_req),
    .dec_ack    (dec_ack),
    .dec_dir    (dec_dir),
    .dec_idx    (dec_idx),
    .res_valid  (res_valid),
    .res_ok     (res_ok),
    .res_err    (res_err)
  );

  function automatic void set_phases(input int pct_ok);
    for (int p = 0; p < MAXPH; p++) begin
      phase_ok[p] = ($urandom_range(0, 99) < pct_ok);
      bad_idx[p]  = $urandom_range(0, DIM - 1);
    end
  endfunction

  // Plays the SISO core for one block and scores the controller against a
  // phase-level model of the stopping rule.
  task automatic run_block(input string name, input int mi, input bit rnd,
                           input int dmin, input int dmax,
                           input int stall_idx, input int stall_len,
                           input int exp_lat, input int abort_pend);
    int lim, iter_e, nph, total, n, k, nres, last_res_n, last_due, stall_left, d;
    bit conv_e, fin, aborted, prev_req, prev_ack, ack, ok;
    logic [IDX_W-1:0] prev_idx;
    logic prev_dir;
    int due_q[$];
    bit ok_q[$];

    lim = (mi == 0) ? 1 : mi;
    iter_e = 0; conv_e = 0; nph = 0; fin = 0;
    while (!fin) begin
      if (phase_ok[nph]) begin
        conv_e = 1;
        if (nph % 2 == 1) iter_e++;
        fin = 1;
      end else if (nph % 2 == 1) begin
        iter_e++;
        if (iter_e == lim) fin = 1;
      end
      nph++;
    end
    total = nph * DIM;

    @(negedge clk);
    max_iter = ITER_W'(mi); start = 1'b1; abort = 1'b0; dec_ack = 1'b0; res_valid = 1'b0;
    n = 0; k = 0; nres = 0; last_res_n = -10; last_due = 0; stall_left = stall_len;
    prev_req = 0; prev_ack = 0; prev_idx = '0; prev_dir = 1'b0; fin = 0; aborted = 0;

    while (!fin) begin
      @(negedge clk);
      n++;
      start = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
      if (n == 1) begin
        checks++;
        if (dec_req !== 1'b1 || dec_idx !== '0 || dec_dir !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s first_req: req=%b idx=%0d dir=%b busy=%b, want 1 0 0 1",
                   name, dec_req, dec_idx, dec_dir, busy);
        end
      end
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL %s timeout: no done after %0d cycles, reqs=%0d want %0d", name, n, k, total);
        fin = 1;
      end else if (done === 1'b1) begin
        checks++;
        if (converged !== conv_e || int'(iter_count) != iter_e || k != total || nres != k ||
            res_err !== 1'b0 || dec_req !== 1'b0 || last_res_n != n - 1) begin
          errors++;
          $display("FAIL %s done: conv=%b iter=%0d reqs=%0d res=%0d err=%b req=%b gap=%0d, want conv=%b iter=%0d reqs=%0d res=%0d err=0 req=0 gap=1",
                   name, converged, iter_count, k, nres, res_err, dec_req, n - last_res_n,
                   conv_e, iter_e, total, total);
        end
        if (exp_lat >= 0) begin
          checks++;
          if (n != exp_lat) begin
            errors++;
            $display("FAIL %s latency: done at cycle %0d, want %0d", name, n, exp_lat);
          end
        end
        fin = 1;
      end else if (abort_pend >= 0 && busy === 1'b1 && dec_dir === 1'b1 && due_q.size() == abort_pend) begin
        abort = 1'b1; dec_ack = 1'b0; res_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || dec_req !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s abort: busy=%b req=%b done=%b, want 0 0 0", name, busy, dec_req, done);
        end
        for (int c = 0; c < 5; c++) begin
          if (due_q.size() > 0) begin
            res_valid = 1'b1; res_ok = ok_q[0];
            void'(due_q.pop_front()); void'(ok_q.pop_front());
          end else begin
            res_valid = 1'b0;
          end
          @(negedge clk);
          checks++;
          if (busy !== 1'b0 || done !== 1'b0 || res_err !== 1'b0) begin
            errors++;
            $display("FAIL %s late_res: busy=%b done=%b err=%b, want 0 0 0", name, busy, done, res_err);
          end
        end
        res_valid = 1'b0;
        fin = 1; aborted = 1;
      end else begin
        if (dec_req === 1'b1) begin
          if (prev_req && !prev_ack) begin
            checks++;
            if (dec_idx !== prev_idx || dec_dir !== prev_dir) begin
              errors++;
              $display("FAIL %s hold: idx=%0d dir=%b, want %0d %b", name, dec_idx, dec_dir, prev_idx, prev_dir);
            end
          end
          if (!prev_req && k > 0) begin
            checks++;
            if (nres != k || last_res_n != n - 1) begin
              errors++;
              $display("FAIL %s phase_start: results=%0d gap=%0d, want results=%0d gap=1",
                       name, nres, n - last_res_n, k);
            end
          end
          if (k >= total) begin
            checks++; errors++;
            $display("FAIL %s extra_req: request %0d, want only %0d", name, k, total);
            fin = 1;
          end
        end
        ack = (dec_req === 1'b1) && !(rnd && $urandom_range(0, 3) == 0);
        if (ack && k < DIM && int'(dec_idx) == stall_idx && stall_left > 0) begin
          ack = 0;
          stall_left--;
        end
        if (ack && k < total) begin
          checks++;
          if (int'(dec_idx) != k % DIM || int'(dec_dir) != (k / DIM) % 2) begin
            errors++;
            $display("FAIL %s order: req %0d idx=%0d dir=%b, want idx=%0d dir=%0d",
                     name, k, dec_idx, dec_dir, k % DIM, (k / DIM) % 2);
          end
          if (phase_ok[k / DIM]) ok = 1'b1;
          else if (k % DIM == bad_idx[k / DIM]) ok = 1'b0;
          else ok = 1'($urandom_range(0, 1));
          d = n + int'($urandom_range(dmin, dmax));
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          due_q.push_back(d);
          ok_q.push_back(ok);
          k++;
        end
        dec_ack = ack;
        if (due_q.size() > 0 && due_q[0] <= n) begin
          res_valid = 1'b1; res_ok = ok_q[0];
          void'(due_q.pop_front()); void'(ok_q.pop_front());
          nres++;
          last_res_n = n;
        end else begin
          res_valid = 1'b0;
          res_ok = 1'($urandom_range(0, 1));
        end
        prev_req = (dec_req === 1'b1); prev_ack = ack; prev_idx = dec_idx; prev_dir = dec_dir;
      end
    end

    start = 1'b0; dec_ack = 1'b0; res_valid = 1'b0; abort = 1'b0;
    if (!aborted) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || converged !== conv_e || int'(iter_count) != iter_e) begin
        errors++;
        $display("FAIL %s after_done: done=%b busy=%b conv=%b iter=%0d, want 0 0 %b %0d",
                 name, done, busy, converged, iter_count, conv_e, iter_e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; max_iter = '0;
    dec_ack = 1'b0; res_valid = 1'b0; res_ok = 1'b0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || converged !== 1'b0 || dec_req !== 1'b0 ||
        dec_dir !== 1'b0 || res_err !== 1'b0 || dec_idx !== '0 || iter_count !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b conv=%b req=%b dir=%b err=%b idx=%0d iter=%0d, want all 0",
               busy, done, converged, dec_req, dec_dir, res_err, dec_idx, iter_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_spurious_and_reset();
    @(negedge clk);
    max_iter = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dec_ack = 1'b0; res_valid = 1'b1; res_ok = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    checks++;
    if (res_err !== 1'b1 || busy !== 1'b1 || dec_req !== 1'b1 || dec_idx !== '0) begin
      errors++;
      $display("FAIL spurious: err=%b busy=%b req=%b idx=%0d, want 1 1 1 0", res_err, busy, dec_req, dec_idx);
    end
    dec_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    dec_ack = 1'b0;
    checks++;
    if (dec_idx !== 2'd2 || res_err !== 1'b1) begin
      errors++;
      $display("FAIL spurious_hold: idx=%0d err=%b, want 2 1", dec_idx, res_err);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || converged !== 1'b0 || dec_req !== 1'b0 ||
        dec_dir !== 1'b0 || res_err !== 1'b0 || dec_idx !== '0 || iter_count !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b conv=%b req=%b dir=%b err=%b idx=%0d iter=%0d, want all 0",
               busy, done, converged, dec_req, dec_dir, res_err, dec_idx, iter_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_two_iters();
    set_phases(0);
    run_block("two_iter", 2, 0, 1, 1, -1, 0, 21, -1);
  endtask

  task automatic test_converge();
    set_phases(0);
    phase_ok[1] = 1;
    run_block("conv_col", 3, 0, 1, 1, -1, 0, 11, -1);
    set_phases(0);
    phase_ok[0] = 1;
    run_block("conv_row", 2, 0, 1, 1, -1, 0, 6, -1);
  endtask

  task automatic test_ack_stall();
    set_phases(0);
    run_block("stall", 1, 0, 1, 1, 2, 3, 14, -1);
  endtask

  task automatic test_slow_results();
    set_phases(0);
    run_block("slow", 1, 0, 5, 5, -1, 0, 19, -1);
  endtask

  task automatic test_abort();
    set_phases(0);
    run_block("abort", 2, 0, 3, 3, -1, 0, -1, 2);
    run_block("after_abort", 1, 0, 1, 1, -1, 0, 11, -1);
  endtask

  task automatic test_max_iter_zero();
    set_phases(0);
    run_block("iter0", 0, 0, 1, 1, -1, 0, 11, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 40; r++) begin
      set_phases(20);
      run_block("random", int'($urandom_range(0, 4)), 1, 1, 4, -1, 0, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_two_iters();
    test_converge();
    test_ack_stall();
    test_slow_results();
    test_abort();
    test_max_iter_zero();
    test_spurious_and_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      set_phases(0);
      run_block("back_to_back", 1, 0, 1, 1, -1, 0, 11, -1);
    end
  endtask

endmodule
